// File: rtl/linebuf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_seq_ctrl
// Purpose  : Per-row sequencer for the 2x2 greyscale line-buffer datapath.
//            Tracks pixel X/Y from the sensor valid strobes, drives the
//            write/read enables of the LINE_WIDTH-deep row FIFO, and flags
//            window validity and frame edges.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iCLK        in   1      pixel clock
//   iRST        in   1      synchronous active-low reset
//   iEN         in   1      sequencer enable; low forces IDLE
//   iFVAL       in   1      frame valid from capture
//   iDVAL       in   1      pixel valid
//   oWREN       out  1      row FIFO write enable (combinational)
//   oRDEN       out  1      row FIFO read enable (combinational)
//   oFIFO_CLR   out  1      1-cycle pulse: empty the FIFO before the next frame
//   oX_Cont     out  CNT_W  column of the pixel accepted one cycle earlier
//   oY_Cont     out  CNT_W  row of the pixel accepted one cycle earlier
//   oWIN_VALID  out  1      full 2x2 window available for that pixel
//   oPIX_VALID  out  1      registered copy of the accepted iDVAL
//   oSOF        out  1      1-cycle start-of-frame pulse
//   oEOF        out  1      1-cycle end-of-frame pulse
//   oERR        out  1      sticky truncation/overrun flag, cleared on ARM entry
// Build option
//   LINEBUF_SEQ_STATS_EN : adds oFRAME_CNT[15:0] (wraps) and oERR_CNT[7:0]
//                          (saturates).
// ============================================================================
module linebuf_seq_ctrl #(
   parameter int LINE_WIDTH  = 1280,
   parameter int FRAME_LINES = 960,
   parameter int CNT_W       = 11
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iEN,
   input  logic             iFVAL,
   input  logic             iDVAL,
   output logic             oWREN,
   output logic             oRDEN,
   output logic             oFIFO_CLR,
   output logic [CNT_W-1:0] oX_Cont,
   output logic [CNT_W-1:0] oY_Cont,
   output logic             oWIN_VALID,
   output logic             oPIX_VALID,
   output logic             oSOF,
   output logic             oEOF,
   output logic             oERR
`ifdef LINEBUF_SEQ_STATS_EN
   ,
   output logic [15:0]      oFRAME_CNT,
   output logic [7:0]       oERR_CNT
`endif
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_ARM     = 3'd1;
   localparam logic [2:0] c_PREFILL = 3'd2;
   localparam logic [2:0] c_STREAM  = 3'd3;
   localparam logic [2:0] c_DONE    = 3'd4;

   localparam logic [CNT_W-1:0] c_X_LAST = CNT_W'(LINE_WIDTH - 1);
   localparam logic [CNT_W-1:0] c_Y_LAST = CNT_W'(FRAME_LINES - 1);

   logic [2:0]       state_q, state_d;
   logic             fval_q;
   logic [CNT_W-1:0] x_q, y_q;
   logic             sat_q;
   logic [CNT_W-1:0] ox_q, oy_q;
   logic             pix_q, win_q, sof_q, err_q, abort_q;
   logic             err_d;

   logic w_in_frame, w_rise, w_accept, w_row_end, w_start, w_overrun, w_set_err;

   assign w_in_frame = (state_q == c_PREFILL) || (state_q == c_STREAM);
   assign w_rise     = iFVAL & ~fval_q;
   // Once the last pixel of the last row is in, the counters are saturated and
   // nothing more is accepted; the frame then ends on the iFVAL fall.
   assign w_accept   = iDVAL & iFVAL & w_in_frame & ~sat_q;
   assign w_row_end  = w_accept & (x_q == c_X_LAST);
   assign w_start    = (state_q == c_ARM) & iEN & w_rise;
   // A pixel beyond the final row while iFVAL is still high is an overrun.
   assign w_overrun  = (state_q == c_STREAM) & sat_q & iFVAL & iDVAL;
   assign w_set_err  = iEN & ((w_in_frame & ~iFVAL & (x_q != '0)) | w_overrun);

   // ---------------- state register ----------------
   always_ff @(posedge iCLK) begin
      if (!iRST) state_q <= c_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (!iEN) begin
         state_d = c_IDLE;
      end else begin
         case (state_q)
            c_IDLE:    state_d = c_ARM;
            c_ARM:     if (w_rise) state_d = c_PREFILL;
            c_PREFILL: begin
               if (!iFVAL)         state_d = c_DONE;
               else if (w_row_end) state_d = c_STREAM;
            end
            c_STREAM:  if (!iFVAL || w_overrun) state_d = c_DONE;
            c_DONE:    state_d = c_ARM;
            default:   state_d = c_IDLE;
         endcase
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      oWREN     = w_accept;
      oRDEN     = w_accept & (state_q == c_STREAM);
      oEOF      = (state_q == c_DONE);
      oFIFO_CLR = (state_q == c_DONE) | abort_q;
   end

   // Entering ARM wipes the error flag; otherwise it is sticky.
   always_comb begin
      err_d = err_q;
      if ((state_d == c_ARM) && (state_q != c_ARM)) err_d = 1'b0;
      else if (w_set_err)                           err_d = 1'b1;
   end

   // ---------------- counters and registered flags ----------------
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         fval_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         sat_q   <= 1'b0;
         ox_q    <= '0;
         oy_q    <= '0;
         pix_q   <= 1'b0;
         win_q   <= 1'b0;
         sof_q   <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         fval_q  <= iFVAL;
         sof_q   <= w_start;
         abort_q <= ~iEN & w_in_frame;
         pix_q   <= w_accept;
         win_q   <= w_accept & (x_q != '0) & (y_q != '0);
         err_q   <= err_d;
         if (w_accept) begin
            ox_q <= x_q;
            oy_q <= y_q;
         end
         if (w_start) begin
            x_q   <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
         end else if (w_accept) begin
            if (x_q == c_X_LAST) begin
               x_q <= '0;
               if (y_q == c_Y_LAST) sat_q <= 1'b1;
               else                 y_q   <= y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
      end
   end

   assign oX_Cont    = ox_q;
   assign oY_Cont    = oy_q;
   assign oPIX_VALID = pix_q;
   assign oWIN_VALID = win_q;
   assign oSOF       = sof_q;
   assign oERR       = err_q;

`ifdef LINEBUF_SEQ_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  err_cnt_q;

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (state_q == c_DONE)                   frame_cnt_q <= frame_cnt_q + 1'b1;
         if (w_set_err && (err_cnt_q != 8'hFF))   err_cnt_q   <= err_cnt_q + 1'b1;
      end
   end

   assign oFRAME_CNT = frame_cnt_q;
   assign oERR_CNT   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_linebuf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_linebuf_seq_ctrl
// Purpose  : Directed self-checking bench for linebuf_seq_ctrl with an 8x4
//            frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linebuf_seq_ctrl;

   localparam int LW    = 8;
   localparam int FL    = 4;
   localparam int CNT_W = 11;

   logic             iCLK = 1'b0;
   logic             iRST, iEN, iFVAL, iDVAL;
   logic             oWREN, oRDEN, oFIFO_CLR, oWIN_VALID, oPIX_VALID, oSOF, oEOF, oERR;
   logic [CNT_W-1:0] oX_Cont, oY_Cont;
`ifdef LINEBUF_SEQ_STATS_EN
   logic [15:0]      oFRAME_CNT;
   logic [7:0]       oERR_CNT;
`endif

   int n_vec = 0;
   int n_err = 0;
   int win_cnt;

   linebuf_seq_ctrl #(.LINE_WIDTH(LW), .FRAME_LINES(FL), .CNT_W(CNT_W)) u_dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iEN        (iEN),
      .iFVAL      (iFVAL),
      .iDVAL      (iDVAL),
      .oWREN      (oWREN),
      .oRDEN      (oRDEN),
      .oFIFO_CLR  (oFIFO_CLR),
      .oX_Cont    (oX_Cont),
      .oY_Cont    (oY_Cont),
      .oWIN_VALID (oWIN_VALID),
      .oPIX_VALID (oPIX_VALID),
      .oSOF       (oSOF),
      .oEOF       (oEOF),
      .oERR       (oERR)
`ifdef LINEBUF_SEQ_STATS_EN
      ,
      .oFRAME_CNT (oFRAME_CNT),
      .oERR_CNT   (oERR_CNT)
`endif
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic cyc();
      @(posedge iCLK);
      #1;
   endtask

   // From ARM: make a clean iFVAL rise and land in PREFILL.
   task automatic start_frame();
      iDVAL = 1'b0;
      iFVAL = 1'b0;
      cyc();
      iFVAL = 1'b1;
      cyc();
      check("sof", oSOF, 1'b1);
   endtask

   // Back-to-back pixels from the start of a frame; expectations from pixel index.
   task automatic feed(input int npix);
      for (int i = 0; i < npix; i++) begin
         int ex, ey;
         ex = i % LW;
         ey = i / LW;
         iDVAL = 1'b1;
         #1;
         check($sformatf("wren[%0d]", i), oWREN, 1'b1);
         check($sformatf("rden[%0d]", i), oRDEN, (i >= LW) ? 1'b1 : 1'b0);
         cyc();
         check($sformatf("pix[%0d]", i), oPIX_VALID, 1'b1);
         check($sformatf("x[%0d]", i), oX_Cont, ex);
         check($sformatf("y[%0d]", i), oY_Cont, ey);
         check($sformatf("win[%0d]", i), oWIN_VALID, (ex != 0 && ey != 0) ? 1'b1 : 1'b0);
         check($sformatf("sof_off[%0d]", i), oSOF, 1'b0);
         if (oWIN_VALID) win_cnt++;
      end
      iDVAL = 1'b0;
   endtask

   // Drop iFVAL, expect DONE with the given error flag, then return to ARM.
   task automatic end_frame(input logic exp_err);
      iDVAL = 1'b0;
      iFVAL = 1'b0;
      #1;
      check("wren_end", oWREN, 1'b0);
      cyc();
      check("eof", oEOF, 1'b1);
      check("clr", oFIFO_CLR, 1'b1);
      check("err_done", oERR, exp_err);
      cyc();
      check("eof_off", oEOF, 1'b0);
      check("clr_off", oFIFO_CLR, 1'b0);
   endtask

   initial begin
      int mx, my;
      logic d;
      iRST = 1'b0; iEN = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0;
      cyc(); cyc();
      iRST = 1'b1;
      #1;
      // Reset state
      check("rst_x", oX_Cont, 0);
      check("rst_y", oY_Cont, 0);
      check("rst_flags", {oWREN, oRDEN, oFIFO_CLR, oWIN_VALID, oPIX_VALID, oSOF, oEOF, oERR}, 8'h00);

      // Test 1: full frame back-to-back
      iEN = 1'b1;
      cyc();
      start_frame();
      win_cnt = 0;
      feed(32);
      check("win_count", win_cnt, 21);
      end_frame(1'b0);

      // Test 2: iDVAL toggling inside rows
      start_frame();
      mx = 0; my = 0; d = 1'b1;
      for (int i = 0; i < 64; i++) begin
         iDVAL = d;
         #1;
         check($sformatf("gap_wren[%0d]", i), oWREN, d);
         cyc();
         check($sformatf("gap_pix[%0d]", i), oPIX_VALID, d);
         if (d) begin
            check($sformatf("gap_x[%0d]", i), oX_Cont, mx);
            check($sformatf("gap_y[%0d]", i), oY_Cont, my);
            if (mx == LW - 1) begin mx = 0; my++; end
            else mx++;
         end
         d = ~d;
      end
      check("gap_final_x", oX_Cont, 7);
      check("gap_final_y", oY_Cont, 3);
      check("gap_rows", my, 4);
      end_frame(1'b0);

      // Test 3: iFVAL falls at row 2, X=5
      start_frame();
      feed(21);
      end_frame(1'b1);
      start_frame();
      check("err_cleared", oERR, 1'b0);
      // Row overrun: one extra pixel after the frame's last pixel
      feed(32);
      iDVAL = 1'b1;
      #1;
      check("ovr_wren", oWREN, 1'b0);
      cyc();
      check("ovr_eof", oEOF, 1'b1);
      check("ovr_err", oERR, 1'b1);
      iDVAL = 1'b0;
      iFVAL = 1'b0;
      cyc();

      // Test 4: iEN drops in STREAM, row 1
      start_frame();
      feed(11);
      iEN = 1'b0;
      cyc();
      check("abort_clr", oFIFO_CLR, 1'b1);
      check("abort_eof", oEOF, 1'b0);
      iDVAL = 1'b1;
      #1;
      check("abort_wren", oWREN, 1'b0);
      check("abort_rden", oRDEN, 1'b0);
      cyc();
      check("abort_clr_off", oFIFO_CLR, 1'b0);
      check("abort_pix", oPIX_VALID, 1'b0);

      // Test 5: reset mid-row 2
      iDVAL = 1'b0;
      iEN = 1'b1;
      cyc();
      start_frame();
      feed(19);
      iDVAL = 1'b1;
      iRST = 1'b0;
      cyc();
      check("mrst_x", oX_Cont, 0);
      check("mrst_y", oY_Cont, 0);
      check("mrst_flags", {oWREN, oRDEN, oFIFO_CLR, oWIN_VALID, oPIX_VALID, oSOF, oEOF, oERR}, 8'h00);
      iRST = 1'b1;
      #1;
      check("mrst_wren_idle", oWREN, 1'b0);
      cyc();
      check("mrst_pix_arm", oPIX_VALID, 1'b0);
      check("mrst_wren_arm", oWREN, 1'b0);
      cyc();
      check("mrst_pix_arm2", oPIX_VALID, 1'b0);
      check("mrst_sof", oSOF, 1'b0);
      start_frame();
      feed(1);
      // Truncated frame (X=1)
      end_frame(1'b1);

      // Test 6: three clean frames after the truncated one
      for (int f = 0; f < 3; f++) begin
         start_frame();
         feed(32);
         end_frame(1'b0);
      end
`ifdef LINEBUF_SEQ_STATS_EN
      check("frame_cnt", oFRAME_CNT, 4);
      check("err_cnt", oERR_CNT, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
